universal_shift_register: RTL and testbench

- Parametrised successor to the 4-bit parallel-in/parallel-out register.
- Adds WIDTH generalisation and eight operating modes: hold, logical shift L/R, rotate L/R, parallel load, clear, arithmetic shift right.
- Provides serial in/out taps and a shift counter with a frame-done pulse, so the block can serialise or deserialise WIDTH-bit words.
- Used as the common shift/serialiser primitive in the sequential library.

---
 rtl/universal_shift_register.sv | 95 +++++++++
 tb/tb_universal_shift_register.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_register.sv
// Universal WIDTH-bit shift register with serial taps and a frame counter for serialise/deserialise use.
// Optional registered parity output when USR_PARITY_EN is defined.
module universal_shift_register #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CW        = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] dout,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic [CW-1:0]    shift_cnt,
  output logic             frame_done
`ifdef USR_PARITY_EN
  ,
  output logic             parity
`endif
);

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_SHL  = 3'b001,
    M_SHR  = 3'b010,
    M_ROL  = 3'b011,
    M_ROR  = 3'b100,
    M_LOAD = 3'b101,
    M_CLR  = 3'b110,
    M_ASR  = 3'b111
  } mode_e;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] dout_nxt;
  logic             is_shift;
  logic             new_frame;

  always_comb begin
    dout_nxt  = dout;
    is_shift  = 1'b0;
    new_frame = 1'b0;
    case (mode_e'(mode))
      M_HOLD: dout_nxt = dout;
      M_SHL:  begin dout_nxt = {dout[WIDTH-2:0], sin_r};        is_shift = 1'b1; end
      M_SHR:  begin dout_nxt = {sin_l, dout[WIDTH-1:1]};        is_shift = 1'b1; end
      M_ROL:  begin dout_nxt = {dout[WIDTH-2:0], dout[WIDTH-1]}; is_shift = 1'b1; end
      M_ROR:  begin dout_nxt = {dout[0], dout[WIDTH-1:1]};      is_shift = 1'b1; end
      M_LOAD: begin dout_nxt = din;                             new_frame = 1'b1; end
      M_CLR:  begin dout_nxt = '0;                              new_frame = 1'b1; end
      M_ASR:  begin dout_nxt = {dout[WIDTH-1], dout[WIDTH-1:1]}; is_shift = 1'b1; end
      default: dout_nxt = dout;
    endcase
  end

  // Counter tracks shift operations regardless of direction; LOAD/CLEAR restart the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= RESET_VAL;
      shift_cnt  <= '0;
      frame_done <= 1'b0;
    end else if (!en) begin
      frame_done <= 1'b0;
    end else begin
      dout <= dout_nxt;
      if (is_shift) begin
        if (shift_cnt == LAST) begin
          shift_cnt  <= '0;
          frame_done <= 1'b1;
        end else begin
          shift_cnt  <= shift_cnt + CW'(1);
          frame_done <= 1'b0;
        end
      end else begin
        if (new_frame) shift_cnt <= '0;
        frame_done <= 1'b0;
      end
    end
  end

`ifdef USR_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  parity <= ^RESET_VAL;
    else if (en) parity <= ^dout_nxt;
  end
`endif

  assign sout_msb = dout[WIDTH-1];
  assign sout_lsb = dout[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// Bench for universal_shift_register (WIDTH=8): directed scenarios plus random stimulus against an arithmetic model.
module tb_universal_shift_register;
  localparam int W  = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [2:0]    mode;
  logic [W-1:0]  din;
  logic          sin_l, sin_r;
  logic [W-1:0]  dout;
  logic          sout_msb, sout_lsb;
  logic [CW-1:0] shift_cnt;
  logic          frame_done;
`ifdef USR_PARITY_EN
  logic          parity;
`endif

  universal_shift_register #(.WIDTH(W), .RESET_VAL('0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .din(din),
    .sin_l(sin_l), .sin_r(sin_r), .dout(dout), .sout_msb(sout_msb),
    .sout_lsb(sout_lsb), .shift_cnt(shift_cnt), .frame_done(frame_done)
`ifdef USR_PARITY_EN
    , .parity(parity)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, plain integers
  int m_dout, m_cnt, m_fd;

  function automatic void model_step(input int e, input int md, input int d, input int sl, input int sr);
    int shifted;
    shifted = 1;
    if (e == 0) begin
      m_fd = 0;
      return;
    end
    case (md)
      1: m_dout = ((m_dout * 2) % 256) + sr;
      2: m_dout = (m_dout / 2) + sl * 128;
      3: m_dout = ((m_dout * 2) % 256) + (m_dout / 128);
      4: m_dout = (m_dout / 2) + (m_dout % 2) * 128;
      7: m_dout = (m_dout / 2) + (m_dout / 128) * 128;
      default: shifted = 0;
    endcase
    if (md == 5) m_dout = d;
    if (md == 6) m_dout = 0;
    m_fd = 0;
    if (shifted == 1) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == W) begin
        m_cnt = 0;
        m_fd  = 1;
      end
    end else if (md == 5 || md == 6) begin
      m_cnt = 0;
    end
  endfunction

  task automatic cyc(input logic e, input logic [2:0] md, input logic [W-1:0] d,
                     input logic sl, input logic sr);
    en = e; mode = md; din = d; sin_l = sl; sin_r = sr;
    @(posedge clk);
    #1;
    model_step(int'(e), int'(md), int'(d), int'(sl), int'(sr));
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; mode = 3'b000; din = '0; sin_l = 1'b0; sin_r = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({dout, shift_cnt, frame_done} !== {8'h00, 3'd0, 1'b0})
      $display("FAIL reset_state: got dout=%h cnt=%0d fd=%b, want 00/0/0", dout, shift_cnt, frame_done);
    else n_pass++;
    #2 rst_n = 1'b1;
    m_dout = 0; m_cnt = 0; m_fd = 0;
    cyc(1, 3'b101, 8'hA5, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 3'b001, '0, 0, 1);
    n_checks++;
    if (shift_cnt !== 3'd5)
      $display("FAIL reset_midframe_pre: got cnt=%0d, want 5", shift_cnt);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({dout, shift_cnt, frame_done} !== {8'h00, 3'd0, 1'b0})
      $display("FAIL reset_async: got dout=%h cnt=%0d fd=%b, want 00/0/0", dout, shift_cnt, frame_done);
    else n_pass++;
    #2 rst_n = 1'b1;
    m_dout = 0; m_cnt = 0; m_fd = 0;
    cyc(1, 3'b101, 8'hA5, 0, 0);
    n_checks++;
    if ({dout, shift_cnt} !== {8'hA5, 3'd0})
      $display("FAIL reset_then_load: got dout=%h cnt=%0d, want a5/0", dout, shift_cnt);
    else n_pass++;
  endtask

  task automatic test_logical;
    cyc(1, 3'b101, 8'hA5, 0, 0);
    cyc(1, 3'b001, '0, 0, 1);
    n_checks++;
    if ({dout, sout_msb} !== {8'h4B, 1'b0})
      $display("FAIL shl: got dout=%h msb=%b, want 4b/0", dout, sout_msb);
    else n_pass++;
    cyc(1, 3'b101, 8'hA5, 0, 0);
    cyc(1, 3'b010, '0, 0, 1);
    n_checks++;
    if ({dout, sout_lsb} !== {8'h52, 1'b0})
      $display("FAIL shr: got dout=%h lsb=%b, want 52/0", dout, sout_lsb);
    else n_pass++;
  endtask

  task automatic test_rotate_arith;
    logic [2:0]   mds  [3] = '{3'b011, 3'b100, 3'b111};
    logic [W-1:0] exps [3] = '{8'h4B, 8'hD2, 8'hD2};
    for (int i = 0; i < 3; i++) begin
      cyc(1, 3'b101, 8'hA5, 0, 0);
      cyc(1, mds[i], '0, 1, 1);
      n_checks++;
      if (dout !== exps[i])
        $display("FAIL rot_asr_%0d: got dout=%h, want %h", i, dout, exps[i]);
      else n_pass++;
    end
    cyc(1, 3'b101, 8'h80, 0, 0);
    cyc(1, 3'b111, '0, 0, 0);
    n_checks++;
    if (dout !== 8'hC0) $display("FAIL asr1: got dout=%h, want c0", dout);
    else n_pass++;
    cyc(1, 3'b111, '0, 0, 0);
    n_checks++;
    if (dout !== 8'hE0) $display("FAIL asr2: got dout=%h, want e0", dout);
    else n_pass++;
  endtask

  task automatic test_frame;
    for (int s = 0; s < 2; s++) begin
      cyc(1, 3'b101, 8'hA5, 0, 0);
      for (int i = 0; i < W; i++) begin
        cyc(1, 3'b001, '0, 0, logic'(s));
        n_checks++;
        if ({shift_cnt, frame_done} !== {3'((i + 1) % W), (i == W - 1)})
          $display("FAIL frame_s%0d_e%0d: got cnt=%0d fd=%b, want %0d/%b",
                   s, i, shift_cnt, frame_done, (i + 1) % W, (i == W - 1));
        else n_pass++;
      end
      n_checks++;
      if (dout !== (s == 1 ? 8'hFF : 8'h00))
        $display("FAIL frame_s%0d_dout: got %h, want %h", s, dout, (s == 1 ? 8'hFF : 8'h00));
      else n_pass++;
      cyc(1, 3'b000, '0, 0, 0);
      n_checks++;
      if (frame_done !== 1'b0) $display("FAIL frame_s%0d_pulse_width: got fd=%b, want 0", s, frame_done);
      else n_pass++;
    end
  endtask

  task automatic test_pause;
    logic [W-1:0] held;
    cyc(1, 3'b101, 8'h3C, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 3'b001, '0, 0, 1);
    held = dout;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 3'b001, 8'hFF, 1, 1);
      n_checks++;
      if ({dout, shift_cnt, frame_done} !== {held, 3'd3, 1'b0})
        $display("FAIL pause_en0_%0d: got dout=%h cnt=%0d fd=%b, want %h/3/0", i, dout, shift_cnt, frame_done, held);
      else n_pass++;
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1, 3'b000, 8'hFF, 1, 1);
      n_checks++;
      if ({dout, shift_cnt, frame_done} !== {held, 3'd3, 1'b0})
        $display("FAIL pause_hold_%0d: got dout=%h cnt=%0d fd=%b, want %h/3/0", i, dout, shift_cnt, frame_done, held);
      else n_pass++;
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1, 3'b001, '0, 0, 0);
      n_checks++;
      if ({shift_cnt, frame_done} !== {3'((4 + i) % W), (i == 4)})
        $display("FAIL pause_resume_%0d: got cnt=%0d fd=%b, want %0d/%b", i, shift_cnt, frame_done, (4 + i) % W, (i == 4));
      else n_pass++;
    end
  endtask

  task automatic test_random;
    logic       e;
    logic [2:0] md;
    for (int i = 0; i < 400; i++) begin
      e  = ($urandom_range(0, 7) != 0);
      md = 3'($urandom_range(0, 7));
      // Bias toward shifts so frames complete regularly
      if ($urandom_range(0, 2) != 0 && (md == 3'b101 || md == 3'b110)) md = 3'b001;
      cyc(e, md, 8'($urandom), 1'($urandom), 1'($urandom));
      n_checks++;
      if ({dout, shift_cnt, frame_done, sout_msb, sout_lsb} !==
          {8'(m_dout), 3'(m_cnt), 1'(m_fd), 1'(m_dout / 128), 1'(m_dout % 2)})
        $display("FAIL random_%0d: got dout=%h cnt=%0d fd=%b, want %h/%0d/%0d", i, dout, shift_cnt, frame_done, m_dout, m_cnt, m_fd);
      else n_pass++;
`ifdef USR_PARITY_EN
      n_checks++;
      if (parity !== ^8'(m_dout))
        $display("FAIL random_parity_%0d: got %b, want %b", i, parity, ^8'(m_dout));
      else n_pass++;
`endif
    end
  endtask

`ifdef USR_PARITY_EN
  task automatic test_parity;
    logic [2:0]   mds  [4] = '{3'b101, 3'b001, 3'b110, 3'b101};
    logic [W-1:0] dins [4] = '{8'hA5, 8'h00, 8'h00, 8'h01};
    logic         exps [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      cyc(1, mds[i], dins[i], 0, 1);
      n_checks++;
      if (parity !== exps[i]) $display("FAIL parity_%0d: got %b, want %b", i, parity, exps[i]);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_logical();
    test_rotate_arith();
    test_frame();
    test_pause();
`ifdef USR_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
